// File: rtl/ps2_rx_fifo_if.sv
// Consumer-side bundle of the PS/2 receiver FIFO: read handshake, occupancy and status pulses.
// master = byte consumer, slave = receiver FIFO.
interface ps2_rx_fifo_if #(
   parameter int FIFO_DEPTH = 8
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic          rd_en;
   logic [7:0]    rd_data;
   logic          empty;
   logic          full;
   logic [CW-1:0] count;
   logic          busy;
   logic          parity_err;
   logic          frame_err;
   logic          overflow;
   logic          timeout_err;

   modport master (
      output rd_en,
      input  rd_data, empty, full, count, busy,
      input  parity_err, frame_err, overflow, timeout_err
   );

   modport slave (
      input  rd_en,
      output rd_data, empty, full, count, busy,
      output parity_err, frame_err, overflow, timeout_err
   );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchroniser, clock glitch filter, frame FSM and show-ahead byte FIFO.
// Optional partial-frame watchdog enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_rx_fifo #(
   parameter int SYNC_STAGES    = 2,
   parameter int FILTER_LEN     = 4,
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           ps2_clk,
   input  logic           ps2_data,
   ps2_rx_fifo_if.slave   bus
);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = AW + 1;
   localparam int FCW = $clog2(FILTER_LEN + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

   logic [SYNC_STAGES-1:0] clk_sync_r;
   logic [SYNC_STAGES-1:0] data_sync_r;
   logic                   clk_s;
   logic                   data_s;
   logic [FCW-1:0]         filt_cnt_r;
   logic                   filt_r;
   logic                   filt_prev_r;
   logic                   fall_s;

   state_t                 state_r, state_n;
   logic [2:0]             bit_cnt_r, bit_cnt_n;
   logic [7:0]             shift_r, shift_n;
   logic                   par_r, par_n;
   logic                   wr_req_s, perr_s, ferr_s, tout_s, tout_hit_s;
   logic                   wr_req_r, parity_err_r, frame_err_r, timeout_err_r, busy_r;

   logic [7:0]             mem_r [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr_r, rd_ptr_r, rd_ptr_n_s;
   logic [CW-1:0]          count_r, count_n_s;
   logic                   empty_r, full_r, overflow_r;
   logic [7:0]             rd_data_r, head_n_s;
   logic                   do_push_s, do_pop_s, ovf_s;

   assign clk_s  = clk_sync_r[SYNC_STAGES-1];
   assign data_s = data_sync_r[SYNC_STAGES-1];
   assign fall_s = filt_prev_r & ~filt_r;

   // Pin synchronisers, preset high to match an idle bus.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync_r  <= {SYNC_STAGES{1'b1}};
         data_sync_r <= {SYNC_STAGES{1'b1}};
      end else begin
         clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], ps2_clk};
         data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], ps2_data};
      end
   end

   // Glitch filter: follow the clock only after FILTER_LEN consecutive differing samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         filt_cnt_r  <= {FCW{1'b0}};
         filt_r      <= 1'b1;
         filt_prev_r <= 1'b1;
      end else begin
         filt_prev_r <= filt_r;
         if (clk_s == filt_r) begin
            filt_cnt_r <= {FCW{1'b0}};
         end else if (filt_cnt_r == FCW'(FILTER_LEN - 1)) begin
            filt_r     <= clk_s;
            filt_cnt_r <= {FCW{1'b0}};
         end else begin
            filt_cnt_r <= filt_cnt_r + FCW'(1'b1);
         end
      end
   end

`ifdef PS2_RX_TIMEOUT_EN
   localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);
   logic [WCW-1:0] wdog_r;

   assign tout_hit_s = (state_r != IDLE) && !fall_s && (wdog_r == WCW'(TIMEOUT_CYCLES - 1));

   // Watchdog: counts idle-bus cycles inside a frame, restarted by every filtered falling edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         wdog_r <= {WCW{1'b0}};
      end else if ((state_r == IDLE) || fall_s || tout_hit_s) begin
         wdog_r <= {WCW{1'b0}};
      end else begin
         wdog_r <= wdog_r + WCW'(1'b1);
      end
   end
`else
   assign tout_hit_s = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

   // Frame FSM state and registered status pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= IDLE;
         bit_cnt_r     <= 3'd0;
         shift_r       <= 8'd0;
         par_r         <= 1'b0;
         wr_req_r      <= 1'b0;
         parity_err_r  <= 1'b0;
         frame_err_r   <= 1'b0;
         timeout_err_r <= 1'b0;
         busy_r        <= 1'b0;
      end else begin
         state_r       <= state_n;
         bit_cnt_r     <= bit_cnt_n;
         shift_r       <= shift_n;
         par_r         <= par_n;
         wr_req_r      <= wr_req_s;
         parity_err_r  <= perr_s;
         frame_err_r   <= ferr_s;
         timeout_err_r <= tout_s;
         busy_r        <= (state_n != IDLE);
      end
   end

   // Next-state logic: one step per filtered falling edge, watchdog abort overrides.
   always_comb begin
      state_n   = state_r;
      bit_cnt_n = bit_cnt_r;
      shift_n   = shift_r;
      par_n     = par_r;
      wr_req_s  = 1'b0;
      perr_s    = 1'b0;
      ferr_s    = 1'b0;
      tout_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (fall_s && (data_s == 1'b0)) begin
               state_n   = DATA;
               bit_cnt_n = 3'd0;
            end else if (fall_s) begin
               ferr_s = 1'b1;
            end else begin
               state_n = IDLE;
            end
         end
         DATA: begin
            if (fall_s) begin
               shift_n = {data_s, shift_r[7:1]};
               if (bit_cnt_r == 3'd7) begin
                  state_n = PARITY;
               end else begin
                  bit_cnt_n = bit_cnt_r + 3'd1;
               end
            end else begin
               state_n = DATA;
            end
         end
         PARITY: begin
            if (fall_s) begin
               par_n   = data_s;
               state_n = STOP;
            end else begin
               state_n = PARITY;
            end
         end
         STOP: begin
            if (fall_s) begin
               state_n  = IDLE;
               wr_req_s = data_s & odd_parity_ok(shift_r, par_r);
               perr_s   = ~odd_parity_ok(shift_r, par_r);
               ferr_s   = ~data_s;
            end else begin
               state_n = STOP;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
      if (tout_hit_s) begin
         state_n = IDLE;
         tout_s  = 1'b1;
      end else begin
         tout_s  = 1'b0;
      end
   end

   // A push while full only succeeds when the same cycle frees a slot.
   assign do_pop_s   = bus.rd_en & ~empty_r;
   assign do_push_s  = wr_req_r & (~full_r | do_pop_s);
   assign ovf_s      = wr_req_r & full_r & ~bus.rd_en;
   assign rd_ptr_n_s = do_pop_s ? (rd_ptr_r + AW'(1'b1)) : rd_ptr_r;
   assign count_n_s  = count_r + CW'(do_push_s) - CW'(do_pop_s);
   assign head_n_s   = (do_push_s && (rd_ptr_n_s == wr_ptr_r)) ? shift_r : mem_r[rd_ptr_n_s];

   // Byte storage, intentionally not reset; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= shift_r;
      end else begin
         mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
      end
   end

   // FIFO pointers, occupancy flags and the registered head byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r   <= {AW{1'b0}};
         rd_ptr_r   <= {AW{1'b0}};
         count_r    <= {CW{1'b0}};
         empty_r    <= 1'b1;
         full_r     <= 1'b0;
         overflow_r <= 1'b0;
         rd_data_r  <= 8'd0;
      end else begin
         wr_ptr_r   <= do_push_s ? (wr_ptr_r + AW'(1'b1)) : wr_ptr_r;
         rd_ptr_r   <= rd_ptr_n_s;
         count_r    <= count_n_s;
         empty_r    <= (count_n_s == {CW{1'b0}});
         full_r     <= (count_n_s == CW'(FIFO_DEPTH));
         overflow_r <= ovf_s;
         rd_data_r  <= head_n_s;
      end
   end

   assign bus.rd_data     = rd_data_r;
   assign bus.empty       = empty_r;
   assign bus.full        = full_r;
   assign bus.count       = count_r;
   assign bus.busy        = busy_r;
   assign bus.parity_err  = parity_err_r;
   assign bus.frame_err   = frame_err_r;
   assign bus.overflow    = overflow_r;
   assign bus.timeout_err = timeout_err_r;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: frames driven bit by bit on the PS/2 pins, outputs checked on negedge.
module tb_ps2_rx_fifo;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ps2_clk = 1'b1;
   logic ps2_data = 1'b1;

   int total = 0;
   int bad = 0;
   int perr_n = 0, ferr_n = 0, ovf_n = 0, tout_n = 0, busy_n = 0;

   ps2_rx_fifo_if #(.FIFO_DEPTH(8)) bus ();

   ps2_rx_fifo #(
      .SYNC_STAGES(2), .FILTER_LEN(4), .FIFO_DEPTH(8), .TIMEOUT_CYCLES(100)
   ) dut (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .bus(bus)
   );

   always #5 clk = ~clk;

   // Pulse/cycle counters; tests compare deltas across a scenario.
   always @(posedge clk) begin
      if (bus.parity_err)  perr_n <= perr_n + 1;
      if (bus.frame_err)   ferr_n <= ferr_n + 1;
      if (bus.overflow)    ovf_n  <= ovf_n + 1;
      if (bus.timeout_err) tout_n <= tout_n + 1;
      if (bus.busy)        busy_n <= busy_n + 1;
   end

   function automatic logic odd_par(input logic [7:0] b);
      return ~^b;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drive the first n bits of f, LSB first; data changes while the clock is high.
   task automatic send_bits(input logic [10:0] f, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_data = f[i];
         tick(4);
         ps2_clk = 1'b0;
         tick(8);
         ps2_clk = 1'b1;
         tick(4);
      end
      ps2_data = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par, input logic stp);
      send_bits({stp, par, b, 1'b0}, 11);
      tick(4);
   endtask

   task automatic pop_one();
      bus.rd_en = 1'b1;
      tick(1);
      bus.rd_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; bus.rd_en = 1'b0;
      tick(3);
      rst = 1'b0;
      tick(1);
      total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", bus.empty); end
      total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", bus.full); end
      total++; if (bus.count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.count); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
      total++; if (bus.rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd_data got=%h want=00", bus.rd_data); end
      total++;
      if ({bus.parity_err, bus.frame_err, bus.overflow, bus.timeout_err} !== 4'b0000) begin
         bad++; $display("FAIL reset_pulses got=%b want=0000",
                         {bus.parity_err, bus.frame_err, bus.overflow, bus.timeout_err});
      end
   endtask

   task automatic test_good_frame();
      int p0, f0;
      p0 = perr_n; f0 = ferr_n;
      send_frame(8'h1C, 1'b0, 1'b1);
      total++; if (bus.empty !== 1'b0) begin bad++; $display("FAIL good_empty got=%b want=0", bus.empty); end
      total++; if (bus.rd_data !== 8'h1C) begin bad++; $display("FAIL good_rd_data got=%h want=1c", bus.rd_data); end
      total++; if (bus.count !== 4'd1) begin bad++; $display("FAIL good_count got=%0d want=1", bus.count); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL good_busy got=%b want=0", bus.busy); end
      total++;
      if ((perr_n - p0) != 0 || (ferr_n - f0) != 0) begin
         bad++; $display("FAIL good_no_err got perr=%0d ferr=%0d want 0 0", perr_n - p0, ferr_n - f0);
      end
      pop_one();
      total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL good_pop_empty got=%b want=1", bus.empty); end
   endtask

   task automatic test_parity_err();
      int p0, f0;
      p0 = perr_n; f0 = ferr_n;
      send_frame(8'h1C, 1'b1, 1'b1);
      total++; if ((perr_n - p0) != 1) begin bad++; $display("FAIL parity_pulse got=%0d want=1", perr_n - p0); end
      total++; if ((ferr_n - f0) != 0) begin bad++; $display("FAIL parity_no_ferr got=%0d want=0", ferr_n - f0); end
      total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL parity_empty got=%b want=1", bus.empty); end
   endtask

   task automatic test_frame_err();
      int p0, f0;
      p0 = perr_n; f0 = ferr_n;
      send_frame(8'hF0, 1'b1, 1'b0);
      total++; if ((ferr_n - f0) != 1) begin bad++; $display("FAIL stop_pulse got=%0d want=1", ferr_n - f0); end
      total++; if ((perr_n - p0) != 0) begin bad++; $display("FAIL stop_no_perr got=%0d want=0", perr_n - p0); end
      total++; if (bus.count !== 4'd0) begin bad++; $display("FAIL stop_count got=%0d want=0", bus.count); end
   endtask

   task automatic test_overflow();
      int o0;
      logic [7:0] b;
      o0 = ovf_n;
      for (int i = 1; i <= 9; i++) begin
         b = 8'(i);
         send_frame(b, odd_par(b), 1'b1);
      end
      total++; if (bus.full !== 1'b1) begin bad++; $display("FAIL ovf_full got=%b want=1", bus.full); end
      total++; if (bus.count !== 4'd8) begin bad++; $display("FAIL ovf_count got=%0d want=8", bus.count); end
      total++; if ((ovf_n - o0) != 1) begin bad++; $display("FAIL ovf_pulse got=%0d want=1", ovf_n - o0); end
      for (int i = 1; i <= 8; i++) begin
         b = 8'(i);
         total++;
         if (bus.rd_data !== b) begin bad++; $display("FAIL ovf_read%0d got=%h want=%h", i, bus.rd_data, b); end
         pop_one();
      end
      total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL ovf_drained got=%b want=1", bus.empty); end
   endtask

   task automatic test_glitch();
      int f0, b0;
      f0 = ferr_n; b0 = busy_n;
      ps2_clk = 1'b0;
      tick(2);
      ps2_clk = 1'b1;
      tick(12);
      total++; if ((ferr_n - f0) != 0) begin bad++; $display("FAIL glitch_ferr got=%0d want=0", ferr_n - f0); end
      total++; if ((busy_n - b0) != 0) begin bad++; $display("FAIL glitch_busy got=%0d want=0", busy_n - b0); end
   endtask

   task automatic test_rst_mid_frame();
      send_frame(8'h33, odd_par(8'h33), 1'b1);
      send_bits({1'b1, 1'b0, 8'h55, 1'b0}, 5);
      tick(2);
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", bus.busy); end
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(1);
      total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL mid_rst_empty got=%b want=1", bus.empty); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b want=0", bus.busy); end
      send_frame(8'hAA, 1'b1, 1'b1);
      total++; if (bus.rd_data !== 8'hAA) begin bad++; $display("FAIL mid_next_data got=%h want=aa", bus.rd_data); end
      total++; if (bus.count !== 4'd1) begin bad++; $display("FAIL mid_next_count got=%0d want=1", bus.count); end
      pop_one();
   endtask

`ifdef PS2_RX_TIMEOUT_EN
   task automatic test_timeout();
      int t0, waited;
      t0 = tout_n;
      waited = 0;
      send_bits({1'b1, 1'b0, 8'h5A, 1'b0}, 5);
      while (tout_n == t0 && waited < 300) begin
         tick(1);
         waited++;
      end
      total++; if ((tout_n - t0) != 1) begin bad++; $display("FAIL tout_pulse got=%0d want=1", tout_n - t0); end
      total++;
      if (waited < 85 || waited > 105) begin
         bad++; $display("FAIL tout_latency got=%0d want=85..105", waited);
      end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL tout_busy got=%b want=0", bus.busy); end
      total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL tout_empty got=%b want=1", bus.empty); end
      send_frame(8'hAA, 1'b1, 1'b1);
      total++; if (bus.rd_data !== 8'hAA) begin bad++; $display("FAIL tout_next got=%h want=aa", bus.rd_data); end
      pop_one();
   endtask
`endif

   initial begin
      bus.rd_en = 1'b0;
      test_reset();
      test_good_frame();
      test_parity_err();
      test_frame_err();
      test_overflow();
      test_glitch();
      test_rst_mid_frame();
`ifdef PS2_RX_TIMEOUT_EN
      test_timeout();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
